mask_bbox_tracker: RTL

- Consumes the active-video pixel stream (hcount/vcount plus a per-pixel 1-bit mask from the colour threshold stage).
- Accumulates the bounding box and pixel count of all masked pixels in each frame.
- At frame end, emits the box in centre/exclusive-max form (x, y, xmax, ymax). The block renderers and the game logic consume this form directly.
- Sits between the mask generator and the sprite/overlay renderers.

---
 rtl/bbox_pkg.sv | 16 +
 rtl/axis_extent.sv | 52 +++++
 rtl/mask_bbox_tracker.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/bbox_pkg.sv
// Shared widths and FSM state type for the mask bounding-box tracker.
// Imported by axis_extent and mask_bbox_tracker.
package bbox_pkg;

  localparam int HC_W  = 11;
  localparam int VC_W  = 10;
  localparam int XO_W  = 12;
  localparam int YO_W  = 11;
  localparam int CNT_W = 20;

  typedef enum logic {
    ACCUM    = 1'b0,
    FINALIZE = 1'b1
  } bbox_state_t;

endpackage

// File: rtl/axis_extent.sv
// Per-axis min / exclusive-max tracker with clear and update inputs.
// Ports: clk, rst_n, clear, update, pos in; lo/hi out (current hit merged in).
module axis_extent
  import bbox_pkg::*;
#(
  parameter int W     = 11,
  parameter int LIMIT = 1280
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         update,
  input  logic [W-1:0] pos,
  output logic [W:0]   lo,
  output logic [W:0]   hi
);

  localparam logic [W:0] LO_INIT = (W+1)'(LIMIT);

  logic [W:0] lo_q;
  logic [W:0] hi_q;
  logic [W:0] p;
  logic [W:0] p1;

  assign p  = {1'b0, pos};
  assign p1 = p + {{W{1'b0}}, 1'b1};

  // lo/hi include this cycle's hit so a snapshot taken
  // on the same edge as a clear still sees it.
  always_comb begin
    lo = lo_q;
    hi = hi_q;
    if (update) begin
      if (p < lo_q)  lo = p;
      if (p1 > hi_q) hi = p1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q <= LO_INIT;
      hi_q <= '0;
    end else if (clear) begin
      lo_q <= LO_INIT;
      hi_q <= '0;
    end else begin
      lo_q <= lo;
      hi_q <= hi;
    end
  end

endmodule

// File: rtl/mask_bbox_tracker.sv
// Per-frame bounding box, hit count and centre of masked pixels.
// Ports: pixel stream + mask + frame_done in; box/count/found/valid out.
module mask_bbox_tracker
  import bbox_pkg::*;
#(
  parameter int H_ACTIVE   = 1280,
  parameter int V_ACTIVE   = 720,
  parameter int MIN_PIXELS = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [HC_W-1:0]  hcount_in,
  input  logic [VC_W-1:0]  vcount_in,
  input  logic             data_valid_in,
  input  logic             mask_in,
  input  logic             frame_done_in,
  output logic [XO_W-1:0]  x_out,
  output logic [YO_W-1:0]  y_out,
  output logic [XO_W-1:0]  xmax_out,
  output logic [YO_W-1:0]  ymax_out,
  output logic [CNT_W-1:0] pixel_count_out,
  output logic             found_out,
  output logic             valid_out
);

  localparam logic [HC_W-1:0]  H_LIM = HC_W'(H_ACTIVE);
  localparam logic [VC_W-1:0]  V_LIM = VC_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_PIXELS);

  bbox_state_t state;

  logic             hit;
  logic             snap;
  logic [XO_W-1:0]  xlo, xhi;
  logic [YO_W-1:0]  ylo, yhi;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             any;

  logic [XO_W-1:0]  s_xlo, s_xhi;
  logic [YO_W-1:0]  s_ylo, s_yhi;
  logic [CNT_W-1:0] s_cnt;
  logic             s_any;

  logic [XO_W:0]    xsum;
  logic [YO_W:0]    ysum;

  assign hit = data_valid_in & mask_in
             & (hcount_in < H_LIM)
             & (vcount_in < V_LIM);

  assign snap = (state == ACCUM) & frame_done_in;

  // Saturating hit counter.
  assign cnt_nxt = (hit && cnt != '1)
                 ? cnt + CNT_W'(1) : cnt;

  axis_extent #(.W(HC_W), .LIMIT(H_ACTIVE)) u_x (
    .clk    (clk_in),
    .rst_n  (rst_n_in),
    .clear  (snap),
    .update (hit),
    .pos    (hcount_in),
    .lo     (xlo),
    .hi     (xhi)
  );

  axis_extent #(.W(VC_W), .LIMIT(V_ACTIVE)) u_y (
    .clk    (clk_in),
    .rst_n  (rst_n_in),
    .clear  (snap),
    .update (hit),
    .pos    (vcount_in),
    .lo     (ylo),
    .hi     (yhi)
  );

  assign xsum = {1'b0, s_xlo} + {1'b0, s_xhi};
  assign ysum = {1'b0, s_ylo} + {1'b0, s_yhi};

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state           <= ACCUM;
      cnt             <= '0;
      any             <= 1'b0;
      s_xlo           <= '0;
      s_xhi           <= '0;
      s_ylo           <= '0;
      s_yhi           <= '0;
      s_cnt           <= '0;
      s_any           <= 1'b0;
      x_out           <= '0;
      y_out           <= '0;
      xmax_out        <= '0;
      ymax_out        <= '0;
      pixel_count_out <= '0;
      found_out       <= 1'b0;
      valid_out       <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      unique case (state)
        ACCUM: begin
          if (frame_done_in) begin
            s_xlo <= xlo;
            s_xhi <= xhi;
            s_ylo <= ylo;
            s_yhi <= yhi;
            s_cnt <= cnt_nxt;
            s_any <= any | hit;
            cnt   <= '0;
            any   <= 1'b0;
            state <= FINALIZE;
          end else begin
            cnt <= cnt_nxt;
            any <= any | hit;
          end
        end
        FINALIZE: begin
          cnt       <= cnt_nxt;
          any       <= any | hit;
          valid_out <= 1'b1;
          state     <= ACCUM;
          if (s_any) begin
            x_out           <= xsum[XO_W:1];
            y_out           <= ysum[YO_W:1];
            xmax_out        <= s_xhi;
            ymax_out        <= s_yhi;
            pixel_count_out <= s_cnt;
            found_out       <= (s_cnt >= MIN_C);
          end else begin
            x_out           <= '0;
            y_out           <= '0;
            xmax_out        <= '0;
            ymax_out        <= '0;
            pixel_count_out <= '0;
            found_out       <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
